cphy_tx_symbol_serializer: RTL and testbench

Master-side (transmit) counterpart of the slave's 7-symbol group capture path. Accepts one 7-symbol C-PHY group per valid/ready handshake and emits it one symbol per clock. Each burst is framed with a sync word before the first group and a post-amble after the last. Sits between the master's word-to-symbol mapper and the lane driver.

---
 rtl/cphy_tx_symbol_serializer_if.sv | 22 ++
 rtl/cphy_tx_symbol_serializer.sv | 127 ++++++++++++
 tb/tb_cphy_tx_symbol_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cphy_tx_symbol_serializer_if.sv
// Group handshake and line-symbol bundle between the symbol mapper, the serializer and the lane driver.
interface cphy_tx_symbol_serializer_if #(
  parameter int SYM_W   = 3,
  parameter int NUM_SYM = 7
);
  logic [NUM_SYM*SYM_W-1:0] group_in;
  logic                     group_valid;
  logic                     group_ready;
  logic [SYM_W-1:0]         sym_out;
  logic                     sym_valid;
  logic                     busy;

  modport slave (
    input  group_in, group_valid,
    output group_ready, sym_out, sym_valid, busy
  );

  modport master (
    output group_in, group_valid,
    input  group_ready, sym_out, sym_valid, busy
  );
endinterface

// File: rtl/cphy_tx_symbol_serializer.sv
// C-PHY transmit serializer: one 7-symbol group per handshake, sent a symbol per clock,
// with a sync word before the first group of a burst and a post-amble after the last.
module cphy_tx_symbol_serializer #(
  parameter int SYM_W    = 3,
  parameter int NUM_SYM  = 7,
  parameter int POST_LEN = 7
) (
  input  logic clk,
  input  logic rst,
  cphy_tx_symbol_serializer_if.slave bus
);
  localparam int GRP_W   = NUM_SYM * SYM_W;
  localparam int CNT_MAX = (NUM_SYM > POST_LEN) ? NUM_SYM : POST_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(NUM_SYM - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, POST} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRP_W-1:0]   shift_q, shift_d;
  logic [GRP_W-1:0]   pend;
  logic               pend_full, pend_full_d, pend_clr;
  logic               accept;
  logic [SYM_W-1:0]   sym_d, sym_q;
  logic               valid_d, valid_q, busy_d, busy_q;

  assign bus.group_ready = !pend_full && !rst;
  assign accept          = bus.group_valid && bus.group_ready;

  assign bus.sym_out   = sym_q;
  assign bus.sym_valid = valid_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    pend_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_full) begin
          state_d = SYNC;
          cnt_d   = '0;
        end
      end
      SYNC: begin
        if (cnt_q == SYM_LAST) begin
          shift_d  = pend;
          pend_clr = 1'b1;
          state_d  = DATA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        // Only a group already sitting in pend may chain; one arriving on this edge waits for POST.
        if (cnt_q == SYM_LAST) begin
          cnt_d = '0;
          if (pend_full) begin
            shift_d  = pend;
            pend_clr = 1'b1;
          end else begin
            state_d = POST;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q >> SYM_W;
        end
      end
      POST: begin
        if (cnt_q == POST_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    sym_d = '0;
    unique case (state_d)
      SYNC:    sym_d = (cnt_d == '0 || cnt_d == SYM_LAST) ? SYM_W'(3) : SYM_W'(4);
      DATA:    sym_d = shift_d[SYM_W-1:0];
      POST:    sym_d = SYM_W'(4);
      default: sym_d = '0;
    endcase
    valid_d     = (state_d != IDLE);
    pend_full_d = (pend_full && !pend_clr) || accept;
    busy_d      = (state_d != IDLE) || pend_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      pend_full <= 1'b0;
      sym_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      pend_full <= pend_full_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend <= bus.group_in;
    end
  end
endmodule

// File: tb/tb_cphy_tx_symbol_serializer.sv
// Self-checking bench: each scenario pushes the cycle-by-cycle expected line stream into a queue
// that a negedge monitor pops and compares against sym_valid/sym_out.
module tb_cphy_tx_symbol_serializer;
  localparam int SYM_W    = 3;
  localparam int NUM_SYM  = 7;
  localparam int POST_LEN = 7;
  localparam int GRP_W    = NUM_SYM * SYM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [SYM_W:0] exp_q[$];

  always #5 clk = ~clk;

  cphy_tx_symbol_serializer_if #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM)) bus ();

  cphy_tx_symbol_serializer #(
    .SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .POST_LEN(POST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [GRP_W-1:0] mkGroup(input int s0, s1, s2, s3, s4, s5, s6);
    int s[7];
    logic [GRP_W-1:0] g;
    s = '{s0, s1, s2, s3, s4, s5, s6};
    g = '0;
    for (int k = 0; k < NUM_SYM; k++) g[k*SYM_W +: SYM_W] = SYM_W'(s[k]);
    return g;
  endfunction

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic pushSync();
    for (int k = 0; k < NUM_SYM; k++)
      exp_q.push_back({1'b1, (k == 0 || k == NUM_SYM - 1) ? SYM_W'(3) : SYM_W'(4)});
  endtask

  task automatic pushData(input logic [GRP_W-1:0] g, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, g[k*SYM_W +: SYM_W]});
  endtask

  task automatic pushPost();
    for (int k = 0; k < POST_LEN; k++) exp_q.push_back({1'b1, SYM_W'(4)});
  endtask

  // Offers a group and returns 1 ns after the edge that accepted it.
  task automatic applyStimulus(input logic [GRP_W-1:0] g);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus.group_in    = g;
      bus.group_valid = 1'b1;
      if (bus.group_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.group_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      bus.group_valid = 1'b0;
      checkOutput("acceptTimeout", 32'(done), 32'd1);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic [SYM_W:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("line", 32'({bus.sym_valid, bus.sym_out}), 32'(e));
    end else begin
      checkOutput("idleValid", 32'(bus.sym_valid), 32'd0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [GRP_W-1:0] g1, g2, g3;
    g1 = mkGroup(0, 1, 2, 3, 4, 0, 1);
    g2 = mkGroup(4, 3, 2, 1, 0, 4, 3);
    g3 = mkGroup(2, 2, 0, 4, 1, 3, 0);

    bus.group_in    = g3;
    bus.group_valid = 1'b1;

    $display("[TB] reset with group_valid held");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstReady", 32'(bus.group_ready), 32'd0);
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstSym", 32'(bus.sym_out), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.group_valid = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRst", 32'(bus.group_ready), 32'd1);
    checkOutput("busyAfterRst", 32'(bus.busy), 32'd0);

    $display("[TB] single group");
    applyStimulus(g1);
    pushIdle(1); pushSync(); pushData(g1, NUM_SYM); pushPost(); pushIdle(2);
    @(negedge clk);
    checkOutput("busyPending", 32'(bus.busy), 32'd1);
    checkOutput("readyPending", 32'(bus.group_ready), 32'd0);
    waitDrain();

    $display("[TB] back-to-back groups");
    applyStimulus(g1);
    pushIdle(1); pushSync(); pushData(g1, NUM_SYM);
    repeat (9) @(posedge clk);
    applyStimulus(g2);
    pushData(g2, NUM_SYM); pushPost(); pushIdle(1);
    waitDrain();

    $display("[TB] second group offered during post-amble");
    applyStimulus(g2);
    pushIdle(1); pushSync(); pushData(g2, NUM_SYM); pushPost();
    repeat (16) @(posedge clk);
    applyStimulus(g3);
    pushIdle(1); pushSync(); pushData(g3, NUM_SYM); pushPost(); pushIdle(1);
    waitDrain();

    $display("[TB] reset mid-data with a group pending");
    applyStimulus(g1);
    pushIdle(1); pushSync(); pushData(g1, 4);
    repeat (7) @(posedge clk);
    applyStimulus(g2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pushIdle(10);
    @(negedge clk);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstReady", 32'(bus.group_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReadyAfter", 32'(bus.group_ready), 32'd1);
    checkOutput("midRstBusyAfter", 32'(bus.busy), 32'd0);
    waitDrain();

    $display("[TB] group_valid toggling while pending is full");
    applyStimulus(g3);
    pushIdle(1); pushSync(); pushData(g3, NUM_SYM); pushPost(); pushIdle(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.group_in    = g2;
      bus.group_valid = (i % 2 == 0);
      checkOutput("readyHeldLow", 32'(bus.group_ready), 32'd0);
    end
    @(negedge clk);
    bus.group_valid = 1'b0;
    waitDrain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
